// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time program loader. Receives a little-endian byte stream, packs it
// into 32-bit words and writes them into the instruction memory. The core is
// held in reset from the moment a load is accepted until the load completes.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_ni         asynchronous active-low reset
//   load_start_i   one-cycle load request, load_len_i sampled with it
//   load_len_i     number of 32-bit words to load (1..DEPTH)
//   abort_i        cancels a load in progress
//   in_valid_i     byte-stream valid
//   in_data_i      byte-stream data
//   in_ready_o     loader accepts a byte this cycle
//   imem_we_o      instruction-memory write strobe, one cycle per word
//   imem_addr_o    word address for imem_we_o
//   imem_wdata_o   assembled instruction word
//   core_rst_n_o   active-low reset to the core
//   busy_o         load in progress (RECV or WRITE)
//   done_o         one-cycle pulse on successful completion
//   err_o          one-cycle pulse on a rejected load_start_i
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for load_start_i
// RECV  | collecting the 4 bytes of the current word
// WRITE | one-cycle write of the assembled word
// DONE  | completion pulse, core released
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_start_i,
    input  logic [ADDR_WIDTH:0]   load_len_i,
    input  logic                  abort_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  core_rst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_L   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_WIDTH:0] len_q;
    logic [ADDR_WIDTH:0] word_cnt_q;
    logic [1:0]          byte_idx_q;
    logic [31:0]         word_q;
    logic                core_rst_n_q;
    logic                err_q;

    logic len_ok;
    logic start_ok;
    logic start_bad;
    logic byte_acc;
    logic last_word;

    assign len_ok    = (load_len_i != '0) && (load_len_i <= DEPTH_L);
    // abort has priority over load_start in IDLE: neither a load nor an error
    assign start_ok  = (state_q == IDLE) && load_start_i && !abort_i && len_ok;
    assign start_bad = (state_q == IDLE) && load_start_i && !abort_i && !len_ok;
    assign byte_acc  = (state_q == RECV) && in_valid_i && !abort_i;
    assign last_word = ((word_cnt_q + ONE_L) == len_q);

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (in_valid_i && (byte_idx_q == 2'd3)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (last_word) begin
                    state_d = DONE;
                end else begin
                    state_d = RECV;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs
    always_comb begin
        in_ready_o   = (state_q == RECV);
        imem_we_o    = (state_q == WRITE) && !abort_i;
        busy_o       = (state_q == RECV) || (state_q == WRITE);
        done_o       = (state_q == DONE);
        imem_addr_o  = word_cnt_q[ADDR_WIDTH-1:0];
        imem_wdata_o = word_q;
        core_rst_n_o = core_rst_n_q;
        err_o        = err_q;
    end

    // datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'd0;
            core_rst_n_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= start_bad;
            if (start_ok) begin
                len_q        <= load_len_i;
                word_cnt_q   <= '0;
                byte_idx_q   <= 2'd0;
                word_q       <= 32'd0;
                core_rst_n_q <= 1'b0;
            end
            if (byte_acc) begin
                word_q[{byte_idx_q, 3'b000} +: 8] <= in_data_i;
                byte_idx_q                        <= byte_idx_q + 2'd1;
            end
            if ((state_q == WRITE) && !abort_i) begin
                if (last_word) begin
                    // released on the DONE cycle itself
                    core_rst_n_q <= 1'b1;
                end else begin
                    word_cnt_q <= word_cnt_q + ONE_L;
                end
            end
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, is the instruction-memory word-address width (DEPTH = 2^ADDR_WIDTH words).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 load_start  input  1  one-cycle request to begin a program load.
REQ-005 load_len  input  ADDR_WIDTH+1  number of 32-bit words to load, sampled when load_start is accepted.
REQ-006 abort  input  1  cancels a load in progress.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  loader can accept a byte this cycle.
REQ-010 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 imem_addr  output  ADDR_WIDTH  word address for imem_we.
REQ-012 imem_wdata  output  32  assembled instruction word.
REQ-013 core_rst_n  output  1  active-low reset to the core; low holds the core (and its control decode) idle.
REQ-014 busy  output  1  high in RECV or WRITE.
REQ-015 done  output  1  one-cycle pulse on successful load completion.
REQ-016 err  output  1  one-cycle pulse on a rejected load_start.

Function
REQ-017 States: IDLE, RECV, WRITE, DONE; the module SHALL hold exactly one of these at all times.
REQ-018 IDLE: load_start with 1 <= load_len <= DEPTH -> RECV next cycle; word_cnt=0, byte_idx=0, core_rst_n driven 0 from the next cycle.
REQ-019 IDLE: load_start with load_len==0 or load_len>DEPTH -> err=1 next cycle, stay IDLE, core_rst_n unchanged.
REQ-020 load_start outside IDLE SHALL be ignored (no err, no state change).
REQ-021 RECV: in_ready=1; a byte is accepted iff in_valid&&in_ready at the clock edge.
REQ-022 Bytes are assembled little-endian: byte_idx 0 -> bits[7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
REQ-023 On acceptance of byte_idx 3: byte_idx wraps to 0, state -> WRITE.
REQ-024 WRITE: in_ready=0; imem_we=1 for exactly this one cycle, imem_addr=word_cnt[ADDR_WIDTH-1:0], imem_wdata=assembled word.
REQ-025 WRITE exit: if word_cnt+1==load_len -> DONE, else word_cnt increments and state -> RECV.
REQ-026 DONE: done=1 for one cycle, core_rst_n=1 from this cycle onward, state -> IDLE next cycle.
REQ-027 Write latency: imem_we asserts on the cycle after the 4th byte of a word is accepted.
REQ-028 Maximum throughput: one word per 5 cycles (4 RECV + 1 WRITE).
REQ-029 abort in RECV or WRITE -> IDLE next cycle; partial word discarded; a WRITE-cycle abort suppresses imem_we; core_rst_n stays 0; no done.
REQ-030 abort in IDLE or DONE is ignored; abort and load_start asserted together in IDLE: abort wins, no load starts, no err.
REQ-031 in_valid with in_ready=0 SHALL not be consumed; the source holds the byte.
REQ-032 imem_addr and imem_wdata are don't-care when imem_we=0, but SHALL not be X after reset.

Reset
REQ-033 rst low SHALL immediately force IDLE, word_cnt=0, byte_idx=0, word register=0, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, core_rst_n=0.
REQ-034 Reset mid-load discards all progress; words already written stay in memory; core_rst_n stays 0 until a later load completes.

Verification
REQ-035 load_len=2, bytes 13 00 00 00 93 00 10 00 back-to-back -> imem_we at addr 0 data 0x00000013, then addr 1 data 0x00100093; done one cycle later; core_rst_n 0->1.
REQ-036 load_len=0, then load_len=DEPTH+1 -> err pulse each time, state IDLE, in_ready=0, no imem_we.
REQ-037 load_len=1 with in_valid gaps of 3 cycles between bytes -> exactly 4 accepted bytes, single imem_we, correct word.
REQ-038 abort after 2 bytes of word 1 (load_len=3) -> IDLE, only word 0 written, core_rst_n=0, no done.
REQ-039 rst low during WRITE -> imem_we drops asynchronously, all outputs at reset values; a fresh load_len=1 then completes normally.
REQ-040 load_start pulsed during RECV -> ignored; load completes with original load_len.
